// File: rtl/uart_tx_slave.sv
// uart_tx_slave: bus-mapped 8N1 UART transmitter with TX FIFO, programmable baud and drain interrupt
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef ZERO_WORD
`define ZERO_WORD {`DATA_BUS_WIDTH{1'b0}}
`endif
module uart_tx_slave #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_DIV_RST = 16'd433
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [`ADDR_BUS_WIDTH-1:0] addr_i,
  input  logic [`DATA_BUS_WIDTH-1:0] data_i,
  input  logic we_i,
  input  logic rd_i,
  output logic [`DATA_BUS_WIDTH-1:0] data_o,
  output logic tx_o,
  output logic irq_o
);
  localparam int DW = `DATA_BUS_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic overflow, tx_en, irq_en, full, empty, busy, wr_data, push, pop, last, tx_d;
  logic [15:0] baud_div, div_q, div_d, cnt, cnt_d;
  logic [7:0] shift, shift_d;
  logic [2:0] bit_idx, bit_d;
  logic [1:0] sel;
  logic [DW-1:0] rdata;
  logic unused_bits;
  assign unused_bits = ^{addr_i[`ADDR_BUS_WIDTH-1:4], addr_i[1:0], data_i[DW-1:16]};
  assign sel = addr_i[3:2];
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign busy = state != IDLE;
  assign wr_data = we_i && sel == 2'd0;
  assign push = wr_data && !full;
  assign pop = state == IDLE && tx_en && !empty;
  assign last = cnt == div_q;
  assign rdata = sel == 2'd0 ? `ZERO_WORD
               : sel == 2'd1 ? DW'({4'(count), overflow, empty, full, busy})
               : sel == 2'd2 ? DW'(baud_div)
               : DW'({irq_en, tx_en});
  assign data_o = rd_i ? rdata : `ZERO_WORD;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_i[7:0];
  // tx_o is registered from the next state so it lines up with the FSM without a cycle of lag
  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d = bit_idx;
    div_d = div_q;
    cnt_d = (state == IDLE || last) ? '0 : cnt + 16'd1;
    case (state)
      IDLE: if (pop) begin
        state_d = START;
        shift_d = mem[rd_ptr];
        div_d = baud_div;
      end
      START: if (last) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (last) begin
        shift_d = shift >> 1;
        bit_d = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_d = STOP;
      end
      default: if (last) state_d = IDLE;
    endcase
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      bit_idx <= '0;
      div_q <= '0;
      tx_o <= 1'b1;
      irq_o <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      baud_div <= BAUD_DIV_RST;
      tx_en <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      shift <= shift_d;
      bit_idx <= bit_d;
      div_q <= div_d;
      tx_o <= tx_d;
      irq_o <= irq_en && empty && !busy;
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (wr_data && full) overflow <= 1'b1;
      else if (we_i && sel == 2'd1 && data_i[3]) overflow <= 1'b0;
      if (we_i && sel == 2'd2) baud_div <= data_i[15:0];
      if (we_i && sel == 2'd3) {irq_en, tx_en} <= data_i[1:0];
    end
endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: register vectors, directed frame sequences and random traffic
// checked every cycle against a frame-schedule model of the serial line and irq.
`timescale 1ns/1ps
module tb_uart_tx_slave;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, we_i = 0, rd_i = 0;
  logic [31:0] addr_i = 0, data_i = 0, data_o;
  logic tx_o, irq_o;
  int checks = 0, failures = 0;
  uart_tx_slave #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(16'd433)) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .we_i(we_i),
    .rd_i(rd_i), .data_o(data_o), .tx_o(tx_o), .irq_o(irq_o));
  always #5 clk = ~clk;
  typedef struct {
    logic we;
    logic rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[13];
  logic [7:0] b5[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [9:0] pat = 10'b1101001010;
  // Model: FIFO as a queue, the current frame as (start edge, divisor, byte)
  logic [7:0] q[$];
  int cyc = 0, fstart = -1000000, fdiv = 0;
  logic [7:0] fbyte = 0;
  logic m_en = 0, m_ien = 0, m_ovf = 0, exp_tx = 1, exp_irq = 0;
  logic [15:0] m_div = 16'd433;
  function automatic bit in_frame(int e);
    return e >= fstart && e - fstart < 10 * (fdiv + 1);
  endfunction
  function automatic logic frame_bit(int e);
    int k;
    k = (e - fstart) / (fdiv + 1);
    return k == 0 ? 1'b0 : k <= 8 ? fbyte[k-1] : 1'b1;
  endfunction
  function automatic logic [31:0] exp_status();
    return {24'h0, 4'(q.size()), m_ovf, q.size() == 0, q.size() == DEPTH, in_frame(cyc)};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    int n;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      fstart = -1000000;
      fdiv = 0;
      m_en = 0;
      m_ien = 0;
      m_ovf = 0;
      m_div = 16'd433;
      exp_tx = 1;
      exp_irq = 0;
    end else begin
      cyc++;
      n = q.size();
      exp_irq = m_ien && n == 0 && !in_frame(cyc - 1);
      if (m_en && n > 0 && !in_frame(cyc - 1)) begin
        fbyte = q.pop_front();
        fdiv = int'(m_div);
        fstart = cyc;
      end
      if (we_i)
        case (addr_i[3:2])
          2'd0: if (n < DEPTH) q.push_back(data_i[7:0]); else m_ovf = 1;
          2'd1: if (data_i[3]) m_ovf = 0;
          2'd2: m_div = data_i[15:0];
          default: {m_ien, m_en} = data_i[1:0];
        endcase
      exp_tx = in_frame(cyc) ? frame_bit(cyc) : 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("tx_line", tx_o, exp_tx);
    chk("irq", irq_o, exp_irq);
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i = 1;
    tick();
    we_i = 0;
  endtask
  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    rd_i = 1;
    #1 chk(name, data_o, exp);
    rd_i = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((q.size() > 0 || in_frame(cyc)) && n < 5000) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 5000), 1);
    repeat (2) tick();
  endtask
  initial begin
    int op;
    vt[0]  = '{1'b0, 1'b1, 32'h8, 32'h0, 32'd433};
    vt[1]  = '{1'b0, 1'b1, 32'hC, 32'h0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 32'h4, 32'h0, 32'h4};
    vt[3]  = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 32'h8, 32'h12345678, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 32'h8, 32'h0, 32'h5678};
    vt[6]  = '{1'b1, 1'b1, 32'h8, 32'h3, 32'h5678};
    vt[7]  = '{1'b0, 1'b1, 32'h8, 32'h0, 32'h3};
    vt[8]  = '{1'b1, 1'b0, 32'hC, 32'hFFFFFFFE, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 32'hC, 32'h0, 32'h2};
    vt[10] = '{1'b0, 1'b1, 32'h34, 32'h0, 32'h4};
    vt[11] = '{1'b1, 1'b0, 32'hC, 32'h0, 32'h0};
    vt[12] = '{1'b0, 1'b1, 32'hC, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    tick();
    foreach (vt[i]) begin
      addr_i = vt[i].addr;
      data_i = vt[i].wd;
      we_i = vt[i].we;
      rd_i = vt[i].rd;
      #1 chk($sformatf("vec%0d", i), data_o, vt[i].exp);
      tick();
      we_i = 0;
      rd_i = 0;
    end
    // 0xA5 at 4 clk/bit
    wr(32'hC, 1);
    wr(32'h0, 32'hA5);
    chk("a5_latency", tx_o, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("a5_bit%0d", i), tx_o, pat[i/4]);
    end
    tick();
    chk("a5_after", tx_o, 1);
    // overflow with transmitter disabled
    wr(32'hC, 0);
    foreach (b5[i]) wr(32'h0, b5[i]);
    rd_chk("status_full", 32'h4, 32'h4A);
    wr(32'h4, 32'h8);
    rd_chk("ovf_clear", 32'h4, 32'h42);
    // reset in the middle of a start bit
    wr(32'hC, 1);
    tick();
    chk("pre_reset_start", tx_o, 0);
    rst_n = 0;
    #1 chk("reset_tx", tx_o, 1);
    chk("reset_irq", irq_o, 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    rd_chk("reset_status", 32'h4, 32'h04);
    rd_chk("reset_baud", 32'h8, 32'd433);
    rd_chk("reset_ctrl", 32'hC, 32'h0);
    tick();
    // back-to-back frames
    wr(32'h8, 3);
    wr(32'h0, 1);
    wr(32'h0, 2);
    wr(32'hC, 1);
    for (int i = 0; i < 86; i++) begin
      tick();
      if (i == 39 || i == 40) chk("b2b_stop_idle", tx_o, 1);
      if (i == 40) rd_chk("b2b_gap_status", 32'h4, 32'h10);
      if (i == 41) begin
        chk("b2b_start2", tx_o, 0);
        rd_chk("b2b_f2_status", 32'h4, 32'h05);
      end
      if (i == 45) chk("b2b_f2_bit0", tx_o, 0);
      if (i == 49) chk("b2b_f2_bit1", tx_o, 1);
    end
    // divisor change mid-frame
    wr(32'h0, 1);
    wr(32'h0, 32'hFF);
    wr(32'h8, 7);
    for (int i = 2; i < 125; i++) begin
      tick();
      if (i == 3) chk("div_f1_start", tx_o, 0);
      if (i == 4 || i == 7) chk("div_f1_bit0", tx_o, 1);
      if (i == 8) chk("div_f1_bit1", tx_o, 0);
      if (i == 48) chk("div_f2_start", tx_o, 0);
      if (i == 49) chk("div_f2_bit0", tx_o, 1);
    end
    drain();
    // drain interrupt
    wr(32'h8, 3);
    wr(32'hC, 3);
    wr(32'h0, 32'h5A);
    for (int i = 0; i < 43; i++) begin
      tick();
      if (i == 39) rd_chk("irq_busy_status", 32'h4, 32'h05);
      if (i == 40) begin
        chk("irq_lag", irq_o, 0);
        rd_chk("irq_idle_status", 32'h4, 32'h04);
      end
      if (i == 41) chk("irq_rise", irq_o, 1);
    end
    wr(32'h0, 32'h00);
    chk("irq_hold", irq_o, 1);
    tick();
    chk("irq_drop", irq_o, 0);
    drain();
    // random traffic
    for (int it = 0; it < 250; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) wr(32'h0, $urandom_range(0, 255));
      else if (op == 4) wr(32'hC, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 32'h1 | ($urandom_range(0, 1) << 1));
      else if (op == 5) wr(32'h8, $urandom_range(0, 4));
      else if (op == 6) wr(32'h4, $urandom_range(0, 15));
      else if (op == 7) begin
        rd_chk("rnd_status", 32'h4, exp_status());
        tick();
      end else if (op == 8) begin
        rd_chk("rnd_baud", 32'h8, {16'h0, m_div});
        tick();
      end else repeat ($urandom_range(1, 40)) tick();
    end
    wr(32'hC, 1);
    drain();
    rd_chk("final_status", 32'h4, exp_status());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
